// File: rtl/axi2mem_pkg.sv
// Shared types and constants for the axi2mem bridge channels.
package axi2mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // Lane 1 sits one 32-bit word above lane 0; one beat spans 8 bytes.
    localparam int unsigned LANE_OFFSET = 4;
    localparam int unsigned BEAT_SHIFT  = 3;

endpackage

// File: rtl/axi2mem_rd_channel_if.sv
// AXI4 AR/R slave-port signal bundle for the axi2mem read channel.
interface axi2mem_rd_channel_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3
);
    logic                      ar_valid;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_region;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [3:0]                ar_qos;
    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_ready;

    logic                      r_valid;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_ready;

    modport slave (
        input  ar_valid, ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst,
               ar_lock, ar_cache, ar_qos, ar_id, ar_user, r_ready,
        output ar_ready, r_valid, r_data, r_resp, r_last, r_id, r_user
    );

    modport master (
        output ar_valid, ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst,
               ar_lock, ar_cache, ar_qos, ar_id, ar_user, r_ready,
        input  ar_ready, r_valid, r_data, r_resp, r_last, r_id, r_user
    );

endinterface

// File: rtl/axi2mem_buffer.sv
// Small ready/valid FIFO; head is visible combinationally. Push is refused when full
// even if a pop happens in the same cycle.
module axi2mem_buffer #(
    parameter int DATA_WIDTH   = 3,
    parameter int BUFFER_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);
    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_reg [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign ready_o = (count_reg != CNT_W'(BUFFER_DEPTH));
    assign valid_o = (count_reg != '0);
    assign data_o  = mem_reg[rd_ptr_reg];
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    always_comb begin
        wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= data_i;
        end
    end

endmodule

// File: rtl/axi2mem_rd_channel.sv
// AXI4 read-path front end: splits 64-bit AR beats into two 32-bit lane commands and
// joins the two lane responses back into one R beat tagged from an ID FIFO.
module axi2mem_rd_channel
    import axi2mem_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int ID_FIFO_DEPTH  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    axi2mem_rd_channel_if.slave  axi_slave,
    output logic [1:0]           trans_req_o,
    output logic [1:0][31:0]     trans_add_o,
    output logic [1:0][5:0]      trans_id_o,
    output logic [1:0]           trans_last_o,
    input  logic [1:0]           trans_gnt_i,
    input  logic [1:0]           trans_r_valid_i,
    input  logic [1:0][31:0]     trans_r_dat_i,
    input  logic [1:0]           trans_r_last_i,
    output logic [1:0]           trans_r_gnt_o
);
    state_t                  state_reg, state_next;
    logic [7:0]              cnt_reg, cnt_next;
    logic [7:0]              len_reg, len_next;
    logic [31:0]             base_reg, base_next;
    logic [1:0]              burst_reg, burst_next;
    logic [AXI_ID_WIDTH-1:0] id_reg, id_next;

    logic                    grant_both;
    logic                    ar_hs;
    logic [31:0]             ar_addr_aligned;
    logic                    beat_req;
    logic                    beat_last;
    logic [31:0]             beat_addr;
    logic [AXI_ID_WIDTH-1:0] beat_id;

    logic                    fifo_ready;
    logic                    fifo_valid;
    logic [AXI_ID_WIDTH-1:0] fifo_head;
    logic                    r_hs;

    assign grant_both      = &trans_gnt_i;
    assign ar_addr_aligned = axi_slave.ar_addr[31:0] & 32'hFFFF_FFF8;
    assign ar_hs           = axi_slave.ar_valid & axi_slave.ar_ready;

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        len_next           = len_reg;
        base_next          = base_reg;
        burst_next         = burst_reg;
        id_next            = id_reg;
        axi_slave.ar_ready = 1'b0;
        beat_req           = 1'b0;
        beat_last          = 1'b0;
        beat_addr          = '0;
        beat_id            = id_reg;

        case (state_reg)
            IDLE: begin
                beat_id = axi_slave.ar_id;
                // rst_ni gates ready so no AR can be taken while reset is held
                axi_slave.ar_ready = grant_both & fifo_ready & rst_ni;
                if (axi_slave.ar_valid & axi_slave.ar_ready) begin
                    beat_req  = 1'b1;
                    beat_addr = ar_addr_aligned;
                    if (axi_slave.ar_len == 8'd0) begin
                        beat_last = 1'b1;
                    end else begin
                        base_next  = ar_addr_aligned;
                        len_next   = axi_slave.ar_len;
                        burst_next = axi_slave.ar_burst;
                        id_next    = axi_slave.ar_id;
                        cnt_next   = 8'd1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (grant_both) begin
                    beat_req = 1'b1;
                    // WRAP deliberately falls through to the incrementing path
                    beat_addr = (burst_reg == AXI_BURST_FIXED) ? base_reg
                              : base_reg + (32'(cnt_reg) << BEAT_SHIFT);
                    if (cnt_reg == len_reg) begin
                        beat_last  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            len_reg   <= '0;
            base_reg  <= '0;
            burst_reg <= '0;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            base_reg  <= base_next;
            burst_reg <= burst_next;
            id_reg    <= id_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign trans_req_o[gi]   = beat_req;
            assign trans_add_o[gi]   = beat_req ? beat_addr + 32'(gi * LANE_OFFSET) : '0;
            assign trans_last_o[gi]  = beat_req & beat_last;
            assign trans_id_o[gi]    = 6'(beat_id);
            assign trans_r_gnt_o[gi] = r_hs;
        end
    endgenerate

    // R join: both lanes and a known burst ID must be present before a beat is offered.
    assign axi_slave.r_valid = (&trans_r_valid_i) & fifo_valid;
    assign axi_slave.r_data  = AXI_DATA_WIDTH'({trans_r_dat_i[1], trans_r_dat_i[0]});
    assign axi_slave.r_last  = trans_r_last_i[0];
    assign axi_slave.r_resp  = AXI_RESP_OKAY;
    assign axi_slave.r_id    = fifo_head;
    assign axi_slave.r_user  = '0;
    assign r_hs              = axi_slave.r_valid & axi_slave.r_ready;

    axi2mem_buffer #(
        .DATA_WIDTH   (AXI_ID_WIDTH),
        .BUFFER_DEPTH (ID_FIFO_DEPTH)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (axi_slave.ar_id),
        .valid_i (ar_hs),
        .ready_o (fifo_ready),
        .data_o  (fifo_head),
        .valid_o (fifo_valid),
        .ready_i (r_hs & axi_slave.r_last)
    );

endmodule

// File: tb/tb_axi2mem_rd_channel.sv
// Directed bench for axi2mem_rd_channel: command split, stalls, bursts, ID FIFO, lane skew, reset.
module tb_axi2mem_rd_channel;
    import axi2mem_pkg::*;

    logic             clk_i;
    logic             rst_ni;
    logic [1:0]       trans_req_o;
    logic [1:0][31:0] trans_add_o;
    logic [1:0][5:0]  trans_id_o;
    logic [1:0]       trans_last_o;
    logic [1:0]       trans_gnt_i;
    logic [1:0]       trans_r_valid_i;
    logic [1:0][31:0] trans_r_dat_i;
    logic [1:0]       trans_r_last_i;
    logic [1:0]       trans_r_gnt_o;

    int n_vec = 0;
    int n_err = 0;

    axi2mem_rd_channel_if #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(3)
    ) axi_if ();

    axi2mem_rd_channel #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(6),
        .AXI_ID_WIDTH(3), .ID_FIFO_DEPTH(2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .axi_slave       (axi_if.slave),
        .trans_req_o     (trans_req_o),
        .trans_add_o     (trans_add_o),
        .trans_id_o      (trans_id_o),
        .trans_last_o    (trans_last_o),
        .trans_gnt_i     (trans_gnt_i),
        .trans_r_valid_i (trans_r_valid_i),
        .trans_r_dat_i   (trans_r_dat_i),
        .trans_r_last_i  (trans_r_last_i),
        .trans_r_gnt_o   (trans_r_gnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic drive_ar(input logic v, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] id);
        axi_if.ar_valid = v;
        axi_if.ar_addr  = addr;
        axi_if.ar_len   = len;
        axi_if.ar_burst = burst;
        axi_if.ar_id    = id;
    endtask

    task automatic drive_lanes(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] last);
        trans_r_valid_i  = v;
        trans_r_dat_i[0] = d0;
        trans_r_dat_i[1] = d1;
        trans_r_last_i   = last;
    endtask

    // One single-beat R handshake; checks the ID at the FIFO head.
    task automatic drain_one(input string tag, input logic [2:0] id);
        drive_lanes(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 2'b11);
        axi_if.r_ready = 1'b1;
        #1;
        check_value({tag, " r_id"}, 64'(axi_if.r_id), 64'(id));
        step();
        drive_lanes(2'b00, 32'h0, 32'h0, 2'b00);
        axi_if.r_ready = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive_ar(1'b0, 32'h0, 8'h0, AXI_BURST_INCR, 3'd0);
        axi_if.ar_prot   = '0;
        axi_if.ar_region = '0;
        axi_if.ar_size   = 3'd3;
        axi_if.ar_lock   = '0;
        axi_if.ar_cache  = '0;
        axi_if.ar_qos    = '0;
        axi_if.ar_user   = '0;
        axi_if.r_ready   = 1'b0;
        trans_gnt_i      = 2'b11;
        drive_lanes(2'b00, 32'h0, 32'h0, 2'b00);

        // Reset state
        step();
        check_value("rst ar_ready", 64'(axi_if.ar_ready), 64'd0);
        check_value("rst trans_req", 64'(trans_req_o), 64'd0);
        check_value("rst r_valid", 64'(axi_if.r_valid), 64'd0);
        rst_ni = 1'b1;
        #1;
        check_value("idle ar_ready", 64'(axi_if.ar_ready), 64'd1);
        step();

        // 1: single beat, unaligned address
        drive_ar(1'b1, 32'h1000_0004, 8'd0, AXI_BURST_INCR, 3'd5);
        #1;
        check_value("t1 ar_ready", 64'(axi_if.ar_ready), 64'd1);
        check_value("t1 req", 64'(trans_req_o), 64'h3);
        check_value("t1 add0", 64'(trans_add_o[0]), 64'h1000_0000);
        check_value("t1 add1", 64'(trans_add_o[1]), 64'h1000_0004);
        check_value("t1 last", 64'(trans_last_o), 64'h3);
        check_value("t1 id", 64'(trans_id_o), 64'({6'd5, 6'd5}));
        step();
        drive_ar(1'b0, 32'h0, 8'd0, AXI_BURST_INCR, 3'd0);
        drive_lanes(2'b11, 32'hAAAA_0000, 32'hBBBB_1111, 2'b11);
        axi_if.r_ready = 1'b1;
        #1;
        check_value("t1 r_valid", 64'(axi_if.r_valid), 64'd1);
        check_value("t1 r_data", axi_if.r_data, 64'hBBBB_1111_AAAA_0000);
        check_value("t1 r_id", 64'(axi_if.r_id), 64'd5);
        check_value("t1 r_last", 64'(axi_if.r_last), 64'd1);
        check_value("t1 r_resp", 64'(axi_if.r_resp), 64'd0);
        check_value("t1 r_gnt", 64'(trans_r_gnt_o), 64'h3);
        step();
        drive_lanes(2'b00, 32'h0, 32'h0, 2'b00);
        axi_if.r_ready = 1'b0;
        #1;
        check_value("t1 fifo empty", 64'(axi_if.r_valid), 64'd0);

        // 2: INCR len=3 with a two-cycle grant stall after beat 1
        drive_ar(1'b1, 32'h0000_0100, 8'd3, AXI_BURST_INCR, 3'd2);
        #1;
        check_value("t2 b0 add0", 64'(trans_add_o[0]), 64'h100);
        check_value("t2 b0 last", 64'(trans_last_o), 64'h0);
        step();
        drive_ar(1'b0, 32'h0, 8'd0, AXI_BURST_INCR, 3'd0);
        #1;
        check_value("t2 run ar_ready", 64'(axi_if.ar_ready), 64'd0);
        check_value("t2 b1 add0", 64'(trans_add_o[0]), 64'h108);
        check_value("t2 b1 last", 64'(trans_last_o), 64'h0);
        step();
        trans_gnt_i = 2'b00;
        #1;
        check_value("t2 stall1 req", 64'(trans_req_o), 64'h0);
        check_value("t2 stall1 add", 64'(trans_add_o), 64'h0);
        step();
        check_value("t2 stall2 req", 64'(trans_req_o), 64'h0);
        step();
        trans_gnt_i = 2'b11;
        #1;
        check_value("t2 b2 add0", 64'(trans_add_o[0]), 64'h110);
        check_value("t2 b2 last", 64'(trans_last_o), 64'h0);
        step();
        check_value("t2 b3 add0", 64'(trans_add_o[0]), 64'h118);
        check_value("t2 b3 add1", 64'(trans_add_o[1]), 64'h11C);
        check_value("t2 b3 last", 64'(trans_last_o), 64'h3);
        check_value("t2 b3 id", 64'(trans_id_o[0]), 64'd2);
        step();
        check_value("t2 idle ar_ready", 64'(axi_if.ar_ready), 64'd1);
        check_value("t2 idle req", 64'(trans_req_o), 64'h0);
        drain_one("t2", 3'd2);

        // 3: FIXED len=2 repeats the same address
        drive_ar(1'b1, 32'h0000_0200, 8'd2, AXI_BURST_FIXED, 3'd3);
        for (int b = 0; b < 3; b++) begin
            #1;
            check_value($sformatf("t3 b%0d add0", b), 64'(trans_add_o[0]), 64'h200);
            check_value($sformatf("t3 b%0d add1", b), 64'(trans_add_o[1]), 64'h204);
            check_value($sformatf("t3 b%0d last", b), 64'(trans_last_o), (b == 2) ? 64'h3 : 64'h0);
            step();
            drive_ar(1'b0, 32'h0, 8'd0, AXI_BURST_INCR, 3'd0);
        end
        drain_one("t3", 3'd3);

        // 4: ID FIFO full blocks the third AR until the first R last
        drive_ar(1'b1, 32'h0000_0300, 8'd0, AXI_BURST_INCR, 3'd1);
        step();
        drive_ar(1'b1, 32'h0000_0308, 8'd0, AXI_BURST_INCR, 3'd2);
        #1;
        check_value("t4 2nd ar_ready", 64'(axi_if.ar_ready), 64'd1);
        step();
        drive_ar(1'b1, 32'h0000_0310, 8'd0, AXI_BURST_INCR, 3'd7);
        drive_lanes(2'b11, 32'h0000_0001, 32'h0000_0002, 2'b11);
        axi_if.r_ready = 1'b1;
        #1;
        check_value("t4 full ar_ready", 64'(axi_if.ar_ready), 64'd0);
        check_value("t4 full req", 64'(trans_req_o), 64'h0);
        check_value("t4 r_id first", 64'(axi_if.r_id), 64'd1);
        step();
        axi_if.r_ready = 1'b0;
        #1;
        check_value("t4 after pop ar_ready", 64'(axi_if.ar_ready), 64'd1);
        check_value("t4 r_id second", 64'(axi_if.r_id), 64'd2);
        step();
        drive_ar(1'b0, 32'h0, 8'd0, AXI_BURST_INCR, 3'd0);
        axi_if.r_ready = 1'b1;
        #1;
        check_value("t4 r_id 2 out", 64'(axi_if.r_id), 64'd2);
        step();
        check_value("t4 r_id 7 out", 64'(axi_if.r_id), 64'd7);
        step();
        drive_lanes(2'b00, 32'h0, 32'h0, 2'b00);
        axi_if.r_ready = 1'b0;
        #1;
        check_value("t4 drained", 64'(axi_if.r_valid), 64'd0);

        // 5: lane skew, lane 1 three cycles late, ready at t+5
        drive_ar(1'b1, 32'h0000_0400, 8'd0, AXI_BURST_INCR, 3'd4);
        step();
        drive_ar(1'b0, 32'h0, 8'd0, AXI_BURST_INCR, 3'd0);
        drive_lanes(2'b01, 32'hCAFE_0000, 32'h0, 2'b01);
        for (int c = 0; c < 3; c++) begin
            #1;
            check_value($sformatf("t5 t+%0d r_valid", c), 64'(axi_if.r_valid), 64'd0);
            check_value($sformatf("t5 t+%0d r_gnt", c), 64'(trans_r_gnt_o), 64'h0);
            step();
        end
        drive_lanes(2'b11, 32'hCAFE_0000, 32'hBEEF_0001, 2'b11);
        for (int c = 3; c < 6; c++) begin
            if (c == 5) axi_if.r_ready = 1'b1;
            #1;
            check_value($sformatf("t5 t+%0d r_valid", c), 64'(axi_if.r_valid), 64'd1);
            check_value($sformatf("t5 t+%0d r_data", c), axi_if.r_data, 64'hBEEF_0001_CAFE_0000);
            check_value($sformatf("t5 t+%0d r_gnt", c), 64'(trans_r_gnt_o), (c == 5) ? 64'h3 : 64'h0);
            step();
        end
        drive_lanes(2'b00, 32'h0, 32'h0, 2'b00);
        axi_if.r_ready = 1'b0;

        // 6: reset in the middle of an 8-beat burst
        drive_ar(1'b1, 32'h0000_0000, 8'd7, AXI_BURST_INCR, 3'd6);
        step();
        drive_ar(1'b0, 32'h0, 8'd0, AXI_BURST_INCR, 3'd0);
        step();
        rst_ni = 1'b0;
        drive_lanes(2'b11, 32'h1, 32'h2, 2'b11);
        #1;
        check_value("t6 rst req", 64'(trans_req_o), 64'h0);
        check_value("t6 rst ar_ready", 64'(axi_if.ar_ready), 64'd0);
        check_value("t6 rst r_valid", 64'(axi_if.r_valid), 64'd0);
        step();
        rst_ni = 1'b1;
        drive_lanes(2'b00, 32'h0, 32'h0, 2'b00);
        drive_ar(1'b1, 32'h0000_0040, 8'd0, AXI_BURST_INCR, 3'd1);
        #1;
        check_value("t6 new ar_ready", 64'(axi_if.ar_ready), 64'd1);
        check_value("t6 new add0", 64'(trans_add_o[0]), 64'h40);
        check_value("t6 new last", 64'(trans_last_o), 64'h3);
        check_value("t6 new id", 64'(trans_id_o[1]), 64'd1);
        step();
        drive_ar(1'b0, 32'h0, 8'd0, AXI_BURST_INCR, 3'd0);
        drain_one("t6", 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
